// File: rtl/pvz_video_pkg.sv
// pvz_video_pkg: image geometry, pixel types and background contents shared by the video pipeline
package pvz_video_pkg;

    localparam int unsigned IMG_W  = 320;
    localparam int unsigned IMG_H  = 240;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned LAT    = 2;

    typedef logic [3:0]        pal_idx_t;
    typedef logic [9:0]        coord_t;
    typedef logic [ADDR_W-1:0] bg_addr_t;

    // Background index image: XOR-fold of the address nibbles, standing in for the image file.
    function automatic pal_idx_t bg_index(bg_addr_t a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {3'b000, a[16]};
    endfunction

endpackage

// File: rtl/pvz_background_fetch_if.sv
// pvz_background_fetch_if: VGA timing in, palette index plus delayed timing out
interface pvz_background_fetch_if import pvz_video_pkg::*; ();

    coord_t     DrawX;
    coord_t     DrawY;
    logic       video_on;
    logic       hsync_in;
    logic       vsync_in;
    logic [8:0] scroll_x;
    pal_idx_t   index;
    logic       video_on_out;
    logic       hsync_out;
    logic       vsync_out;

    modport master (
        output DrawX, DrawY, video_on, hsync_in, vsync_in, scroll_x,
        input  index, video_on_out, hsync_out, vsync_out
    );

    modport slave (
        input  DrawX, DrawY, video_on, hsync_in, vsync_in, scroll_x,
        output index, video_on_out, hsync_out, vsync_out
    );

endinterface

// File: rtl/pvz_background_rom.sv
// pvz_background_rom: single-port background index ROM with one-cycle registered read
module pvz_background_rom import pvz_video_pkg::*; (
    input  logic     Clk,
    input  bg_addr_t addr_i,
    output pal_idx_t data_o
);

    pal_idx_t data_q;

    // Registered read; contents need no reset since the fetch stage gates them.
    always_ff @(posedge Clk) begin
        data_q <= bg_index(addr_i);
    end

    assign data_o = data_q;

endmodule

// File: rtl/pvz_background_fetch.sv
// pvz_background_fetch: DrawX/DrawY to background palette index with 2x upscale and per-frame scroll
module pvz_background_fetch import pvz_video_pkg::*; (
    input  logic                  Clk,
    input  logic                  Reset,
    pvz_background_fetch_if.slave bus
);

    logic       vs_prev_q;
    logic [8:0] scroll_q, scroll_d;
    logic [8:0] x_img, y_img;
    logic [9:0] xs_sum, xs;
    bg_addr_t   addr_d, addr_q;
    logic       in_range_d, in_range_q, in_range2_q;
    logic       von1_q, hs1_q, vs1_q;
    logic       von2_q, hs2_q, vs2_q;
    pal_idx_t   rom_data;
    logic       unused_lsb;

    assign unused_lsb = bus.DrawX[0] ^ bus.DrawY[0];

    // Scroll latch on vsync falling edge, folded into 0..IMG_W-1; stage-1 address generation.
    always_comb begin
        scroll_d   = scroll_q;
        if (vs_prev_q && !bus.vsync_in)
            scroll_d = (bus.scroll_x < 9'(IMG_W)) ? bus.scroll_x : bus.scroll_x - 9'(IMG_W);
        x_img      = bus.DrawX[9:1];
        y_img      = bus.DrawY[9:1];
        xs_sum     = {1'b0, x_img} + {1'b0, scroll_q};
        xs         = (xs_sum >= 10'(IMG_W)) ? xs_sum - 10'(IMG_W) : xs_sum;
        in_range_d = bus.video_on && (y_img < 9'(IMG_H)) && (x_img < 9'(IMG_W));
        addr_d     = in_range_d ? (ADDR_W'(y_img) << 8) + (ADDR_W'(y_img) << 6) + ADDR_W'(xs) : '0;
    end

    // Two-stage pipeline registers; sync lines reset to their inactive high level.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_prev_q   <= 1'b1;
            scroll_q    <= '0;
            addr_q      <= '0;
            in_range_q  <= 1'b0;
            in_range2_q <= 1'b0;
            von1_q      <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            von2_q      <= 1'b0;
            hs2_q       <= 1'b1;
            vs2_q       <= 1'b1;
        end else begin
            vs_prev_q   <= bus.vsync_in;
            scroll_q    <= scroll_d;
            addr_q      <= addr_d;
            in_range_q  <= in_range_d;
            in_range2_q <= in_range_q;
            von1_q      <= bus.video_on;
            hs1_q       <= bus.hsync_in;
            vs1_q       <= bus.vsync_in;
            von2_q      <= von1_q;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
        end
    end

    pvz_background_rom u_rom (
        .Clk    (Clk),
        .addr_i (addr_q),
        .data_o (rom_data)
    );

    assign bus.index        = in_range2_q ? rom_data : '0;
    assign bus.video_on_out = von2_q;
    assign bus.hsync_out    = hs2_q;
    assign bus.vsync_out    = vs2_q;

endmodule

// File: tb/tb_pvz_background_fetch.sv
// tb_pvz_background_fetch: random and directed checks of the background fetch against a frame-level model
module tb_pvz_background_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pvz_background_fetch_if bus();

    pvz_background_fetch dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int sx      = 0;

    int       m_scroll   = 0;
    bit       m_prev_vs  = 1'b1;
    bit       m_rst_prev = 1'b1;
    bit [6:0] m_pend     = 7'b0000011;
    bit [6:0] m_exp      = 7'b0000011;

    function automatic int rom(int a);
        int h = 0;
        for (int i = 0; i < 5; i++) h ^= (a >> (4 * i)) & 15;
        return h;
    endfunction

    function automatic bit [3:0] pix(int x, int y, bit von, int sc);
        if (!von || x >= 640 || y >= 480) return 4'd0;
        return 4'(rom((y / 2) * 320 + ((x / 2 + sc) % 320)));
    endfunction

    task automatic model_step();
        int x = int'(bus.DrawX);
        int y = int'(bus.DrawY);
        int s = int'(bus.scroll_x);
        m_exp      = (rst || m_rst_prev) ? 7'b0000011 : m_pend;
        m_pend     = {pix(x, y, bus.video_on, m_scroll), bus.video_on, bus.hsync_in, bus.vsync_in};
        m_rst_prev = rst;
        if (rst) begin
            m_scroll  = 0;
            m_prev_vs = 1'b1;
        end else begin
            if (m_prev_vs && !bus.vsync_in) m_scroll = (s < 320) ? s : s - 320;
            m_prev_vs = bus.vsync_in;
        end
    endtask

    task automatic chk(string name, int got, int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic cyc(int x, int y, bit von, bit hs, bit vs);
        bus.DrawX    = 10'(x);
        bus.DrawY    = 10'(y);
        bus.video_on = von;
        bus.hsync_in = hs;
        bus.vsync_in = vs;
        bus.scroll_x = 9'(sx);
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("index",        int'(bus.index),        int'(m_exp[6:3]));
        chk("video_on_out", int'(bus.video_on_out), int'(m_exp[2]));
        chk("hsync_out",    int'(bus.hsync_out),    int'(m_exp[1]));
        chk("vsync_out",    int'(bus.vsync_out),    int'(m_exp[0]));
    endtask

    task automatic idle(bit vs);
        cyc(0, 0, 1'b0, 1'b1, vs);
    endtask

    task automatic vs_start();
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);
    endtask

    task automatic pin_reset(string name);
        chk({name, "_index"}, int'(bus.index), 0);
        chk({name, "_von"},   int'(bus.video_on_out), 0);
        chk({name, "_hs"},    int'(bus.hsync_out), 1);
        chk({name, "_vs"},    int'(bus.vsync_out), 1);
    endtask

    task automatic pin_px(string name, int x, int y, int addr);
        cyc(x, y, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk(name, int'(bus.index), rom(addr));
        chk({name, "_von"}, int'(bus.video_on_out), 1);
        chk({name, "_hs"},  int'(bus.hsync_out), 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(123, 45, 1'b1, 1'b0, 1'b0);
            pin_reset("reset_hold");
        end
        rst = 1'b0;
        idle(1'b1);
        idle(1'b1);

        pin_px("scroll0_965", 10, 6, 965);

        sx = 318;
        vs_start();
        pin_px("scroll318_963", 10, 6, 963);
        sx = 5;
        pin_px("midframe_963", 10, 6, 963);

        sx = 400;
        vs_start();
        pin_px("scroll400_1045", 10, 6, 1045);

        sx = 0;
        vs_start();
        pin_px("corner_76799", 639, 479, 76799);
        sx = 1;
        vs_start();
        pin_px("corner_wrap_76480", 639, 479, 76480);

        cyc(300, 200, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        chk("blank_index", int'(bus.index), 0);
        chk("blank_von",   int'(bus.video_on_out), 0);

        cyc(700, 100, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        chk("oob_x_index", int'(bus.index), 0);
        cyc(100, 500, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        chk("oob_y_index", int'(bus.index), 0);

        sx = 100;
        vs_start();
        cyc(20, 20, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        cyc(22, 20, 1'b1, 1'b1, 1'b1);
        pin_reset("midreset");
        cyc(24, 20, 1'b1, 1'b1, 1'b1);
        cyc(26, 20, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        cyc(10, 6, 1'b1, 1'b0, 1'b1);
        pin_reset("post_reset_flush");
        idle(1'b1);
        chk("post_reset_965", int'(bus.index), rom(965));

        sx = 77;
        vs_start();
        for (int x = 0; x < 640; x++) cyc(x, 37, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 31) == 0) sx = int'($urandom_range(0, 511));
            rst = ($urandom_range(0, 199) == 0);
            cyc(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 15) != 0));
        end
        rst = 1'b0;
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
